// File: rtl/i2s_rx_lock_ctrl.sv
// I2S receive lock controller: measures lrck frame period and duty in bclk cycles,
// locks after repeated identical legal frames and gates receiver valid until locked.
module i2s_rx_lock_ctrl #(
  parameter int CNT_W       = 10,
  parameter int MIN_FRAME   = 32,
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 2
) (
  input  logic             bclk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             lrck,
  input  logic             rx_valid,
  output logic             locked,
  output logic [CNT_W-1:0] frame_len,
  output logic [CNT_W-1:0] ch_bits,
  output logic             out_valid,
  output logic             fmt_err
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);
  localparam int MS_W = $clog2(LOSS_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_FRAME);
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_FRAMES - 1);
  localparam logic [MS_W-1:0]  LOSS_LAST = MS_W'(LOSS_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  state_t           state_reg, state_next;
  logic             lrck_q;
  logic [CNT_W-1:0] pcnt_reg, pcnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] ref_reg, ref_next;
  logic [CNT_W-1:0] frame_len_reg, frame_len_next;
  logic [MC_W-1:0]  mcnt_reg, mcnt_next;
  logic [MS_W-1:0]  miss_reg, miss_next;
  logic             locked_reg;
  logic             fmt_err_reg, fmt_err_next;
  logic             fb, ovf, legal, match;
  logic [CNT_W-1:0] meas, high;

  // Measurement includes the boundary edge itself, so a frame of N bclk yields meas=N.
  assign fb    = lrck_q & ~lrck;
  assign ovf   = (pcnt_reg == CNT_MAX);
  assign meas  = pcnt_reg + CNT_W'(1);
  assign high  = hcnt_reg + CNT_W'(lrck_q);
  assign legal = ~meas[0] && (meas >= MIN_LEN) && (high == (meas >> 1)) && ~ovf;
  assign match = legal && (meas == frame_len_reg);

  always_comb begin
    pcnt_next = pcnt_reg;
    hcnt_next = hcnt_reg;
    if (!cfg_en || state_reg == S_IDLE || fb) begin
      pcnt_next = '0;
      hcnt_next = '0;
    end else if (!ovf) begin
      pcnt_next = pcnt_reg + CNT_W'(1);
      hcnt_next = hcnt_reg + CNT_W'(lrck_q);
    end
  end

  always_comb begin
    state_next     = state_reg;
    ref_next       = ref_reg;
    mcnt_next      = mcnt_reg;
    miss_next      = miss_reg;
    frame_len_next = frame_len_reg;
    fmt_err_next   = 1'b0;
    if (!cfg_en) begin
      state_next     = S_IDLE;
      ref_next       = '0;
      mcnt_next      = '0;
      miss_next      = '0;
      frame_len_next = '0;
    end else begin
      case (state_reg)
        S_IDLE:   state_next = S_SEARCH;
        S_SEARCH: if (fb) state_next = S_ACQUIRE;
        S_ACQUIRE: begin
          if (ovf) begin
            state_next   = S_SEARCH;
            fmt_err_next = 1'b1;
            ref_next     = '0;
            mcnt_next    = '0;
          end else if (fb) begin
            if (legal && meas == ref_reg) begin
              if (mcnt_reg == LOCK_LAST) begin
                state_next     = S_LOCKED;
                frame_len_next = ref_reg;
                mcnt_next      = '0;
                miss_next      = '0;
              end else begin
                mcnt_next = mcnt_reg + MC_W'(1);
              end
            end else begin
              ref_next  = meas;
              mcnt_next = legal ? MC_W'(1) : '0;
            end
          end
        end
        S_LOCKED: begin
          // Overflow or too many consecutive bad frames: back to a fresh search.
          if (ovf || (fb && !match && miss_reg == LOSS_LAST)) begin
            state_next     = S_SEARCH;
            fmt_err_next   = 1'b1;
            frame_len_next = '0;
            ref_next       = '0;
            mcnt_next      = '0;
            miss_next      = '0;
          end else if (fb) begin
            miss_next = match ? '0 : miss_reg + MS_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      lrck_q        <= 1'b0;
      pcnt_reg      <= '0;
      hcnt_reg      <= '0;
      ref_reg       <= '0;
      mcnt_reg      <= '0;
      miss_reg      <= '0;
      frame_len_reg <= '0;
      locked_reg    <= 1'b0;
      fmt_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lrck_q        <= lrck;
      pcnt_reg      <= pcnt_next;
      hcnt_reg      <= hcnt_next;
      ref_reg       <= ref_next;
      mcnt_reg      <= mcnt_next;
      miss_reg      <= miss_next;
      frame_len_reg <= frame_len_next;
      locked_reg    <= (state_next == S_LOCKED);
      fmt_err_reg   <= fmt_err_next;
    end
  end

  assign locked    = locked_reg;
  assign frame_len = frame_len_reg;
  assign ch_bits   = {1'b0, frame_len_reg[CNT_W-1:1]};
  assign out_valid = rx_valid & locked_reg;
  assign fmt_err   = fmt_err_reg;

endmodule

// File: tb/tb_i2s_rx_lock_ctrl.sv
// Frame-level bench for i2s_rx_lock_ctrl: drives lrck frames, predicts lock state per frame
// and checks it through a scoreboard sampled on each rx_valid pulse.
module tb_i2s_rx_lock_ctrl;
  localparam int CNT_W       = 10;
  localparam int MIN_FRAME   = 32;
  localparam int LOCK_FRAMES = 4;
  localparam int LOSS_FRAMES = 2;

  logic             bclk = 1'b0;
  logic             rst, cfg_en, lrck, rx_valid;
  logic             locked, out_valid, fmt_err;
  logic [CNT_W-1:0] frame_len, ch_bits;

  i2s_rx_lock_ctrl #(
    .CNT_W(CNT_W), .MIN_FRAME(MIN_FRAME), .LOCK_FRAMES(LOCK_FRAMES), .LOSS_FRAMES(LOSS_FRAMES)
  ) dut (
    .bclk(bclk), .rst(rst), .cfg_en(cfg_en), .lrck(lrck), .rx_valid(rx_valid),
    .locked(locked), .frame_len(frame_len), .ch_bits(ch_bits),
    .out_valid(out_valid), .fmt_err(fmt_err)
  );

  always #5 bclk = ~bclk;

  typedef struct { bit lk; int flen; int fmt; } exp_t;
  typedef enum {M_OFF, M_SEARCH, M_ACQ, M_LOCK} mph_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_pass = 0, fmt_seen = 0, txn = 0;

  // Reference model: state tracked per frame, not per edge
  mph_t ph = M_OFF;
  int   hist[$];
  int   m_len = 0, bad_run = 0, fmt_exp = 0, prev_n = 0, prev_h = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit frame_legal(input int n, input int h);
    return (n % 2 == 0) && (n >= MIN_FRAME) && (2 * h == n) && (n < (1 << CNT_W));
  endfunction

  function automatic bit last_run_locks();
    int sz = hist.size();
    if (sz < LOCK_FRAMES || hist[sz-1] < 0) return 1'b0;
    for (int i = sz - LOCK_FRAMES; i < sz; i++)
      if (hist[i] != hist[sz-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_drop();
    fmt_exp++;
    ph = M_SEARCH;
    m_len = 0;
    bad_run = 0;
    hist.delete();
  endtask

  task automatic model_clear(input bit en);
    ph = en ? M_SEARCH : M_OFF;
    m_len = 0;
    bad_run = 0;
    hist.delete();
  endtask

  // Frame boundary that ends the previous frame (prev_n, prev_h).
  task automatic model_fb(input bit en);
    if (!en) model_clear(1'b0);
    else begin
      case (ph)
        M_OFF:    ph = M_SEARCH;
        M_SEARCH: begin ph = M_ACQ; hist.delete(); end
        M_ACQ: begin
          hist.push_back(frame_legal(prev_n, prev_h) ? prev_n : -1);
          if (last_run_locks()) begin ph = M_LOCK; m_len = prev_n; bad_run = 0; end
        end
        M_LOCK: begin
          if (frame_legal(prev_n, prev_h) && prev_n == m_len) bad_run = 0;
          else bad_run++;
          if (bad_run >= LOSS_FRAMES) model_drop();
        end
      endcase
    end
  endtask

  // One frame: L low cycles then H high cycles; rx_valid pulses mid-high.
  task automatic frame(input int L, input int H, input bit en, input bit do_rst);
    exp_t e;
    cfg_en = en;
    model_fb(en);
    if (L + H >= (1 << CNT_W) && (ph == M_ACQ || ph == M_LOCK)) model_drop();
    for (int i = 0; i < L; i++) begin
      lrck = 1'b0;
      rx_valid = 1'b0;
      if (do_rst && i == L / 2) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear(en);
      end
      @(posedge bclk); #1;
    end
    for (int i = 0; i < H; i++) begin
      lrck = 1'b1;
      rx_valid = (i == H / 2);
      if (rx_valid) begin
        e.lk = (ph == M_LOCK);
        e.flen = m_len;
        e.fmt = fmt_exp;
        sb_q.push_back(e);
      end
      @(posedge bclk); #1;
    end
    rx_valid = 1'b0;
    prev_n = L + H;
    prev_h = H;
  endtask

  // Monitor: counts fmt_err pulses, pops an expectation on every rx_valid
  always @(negedge bclk) begin
    exp_t e;
    if (fmt_err === 1'b1) fmt_seen++;
    if (rx_valid === 1'b1) begin
      check("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d: locked=%0b frame_len=%0d ch_bits=%0d out_valid=%0b fmt_pulses=%0d (exp lk=%0b len=%0d fmt=%0d)",
                 txn, locked, frame_len, ch_bits, out_valid, fmt_seen, e.lk, e.flen, e.fmt);
        check("out_valid", int'(out_valid), int'(e.lk));
        check("locked", int'(locked), int'(e.lk));
        check("frame_len", int'(frame_len), e.flen);
        check("ch_bits", int'(ch_bits), e.flen / 2);
        check("fmt_err_count", fmt_seen, e.fmt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_en = 1'b0; lrck = 1'b1; rx_valid = 1'b0;
    repeat (3) @(posedge bclk);
    @(negedge bclk);
    check("reset_locked", int'(locked), 0);
    check("reset_frame_len", int'(frame_len), 0);
    check("reset_ch_bits", int'(ch_bits), 0);
    check("reset_fmt_err", int'(fmt_err), 0);
    check("reset_out_valid", int'(out_valid), 0);
    @(posedge bclk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge bclk); #1; end

    // Lock on 64-bclk frames, single bad frame tolerated, two drop lock
    repeat (6) frame(32, 32, 1'b1, 1'b0);
    frame(31, 31, 1'b1, 1'b0);
    frame(32, 32, 1'b1, 1'b0);
    frame(31, 31, 1'b1, 1'b0);
    frame(31, 31, 1'b1, 1'b0);
    frame(32, 32, 1'b1, 1'b0);
    // Bad duty cycle never locks
    repeat (6) frame(30, 18, 1'b1, 1'b0);
    // Lock at 128, overflow, relock
    repeat (7) frame(64, 64, 1'b1, 1'b0);
    frame(1100, 64, 1'b1, 1'b0);
    repeat (6) frame(64, 64, 1'b1, 1'b0);
    // Enable dropped on a boundary while locked, then reset mid-acquire
    frame(64, 64, 1'b0, 1'b0);
    repeat (4) frame(64, 64, 1'b1, 1'b0);
    frame(64, 64, 1'b1, 1'b1);
    repeat (6) frame(64, 64, 1'b1, 1'b0);

    for (int b = 0; b < 30; b++) begin
      int half = $urandom_range(14, 80);
      int reps = $urandom_range(3, 8);
      for (int r = 0; r < reps; r++) begin
        int L = half, H = half, k = $urandom_range(0, 39);
        bit en = 1'b1, dr = 1'b0;
        if (k < 3) begin L = half - 1; H = half - 1; end
        else if (k < 6) begin L = half + 1; H = half - 1; end
        else if (k < 8) H = half + 1;
        else if (k == 8) en = 1'b0;
        else if (k == 9) dr = 1'b1;
        else if (k == 10) L = 1100;
        frame(L, H, en, dr);
      end
    end

    repeat (4) begin @(posedge bclk); #1; end
    @(negedge bclk);
    check("sb_drained", sb_q.size(), 0);
    check("fmt_err_total", fmt_seen, fmt_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
